// File: rtl/ofm_drain_sequencer.sv
// Frame controller around the convolution top level: launches a convolution,
// then drains every filter's OFM through a one-word capture stage onto a byte stream.
module ofm_drain_sequencer #(
  parameter int CONV_NUM  = 4,
  parameter int OFM_WORDS = 256,
  parameter int IDX_W     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  output logic                     conv_start,
  input  logic                     conv_done,
  output logic [CONV_NUM*10-1:0]   ofm_addr,
  input  logic [CONV_NUM*8-1:0]    ofm_in,
  output logic [7:0]               out_data,
  output logic [IDX_W-1:0]         out_filter,
  output logic [9:0]               out_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    FETCH     = 3'd3,
    CAPTURE   = 3'd4,
    EMIT      = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [IDX_W-1:0]    filt, filt_nxt;
  logic                cap_en;
  logic                last_filt, last_addr;
  logic [DATA_W-1:0]   ofm_p1 [CONV_NUM];
  logic [DATA_W-1:0]   sel_data;

  assign last_filt = (filt == IDX_W'(CONV_NUM - 1));
  assign last_addr = (addr == ADDR_W'(OFM_WORDS - 1));

  // The address only moves on WAIT_DONE exit or after the last filter of a word,
  // so every bank sees a stable address from FETCH through EMIT.
  assign ofm_addr = {CONV_NUM{addr}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr  <= '0;
      filt  <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      filt  <= filt_nxt;
    end
  end

  // ---- stage p1: one OFM word per bank, captured the cycle after FETCH ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < CONV_NUM; k++) ofm_p1[k] <= '0;
    end else if (cap_en) begin
      for (int k = 0; k < CONV_NUM; k++) ofm_p1[k] <= ofm_in[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    filt_nxt   = filt;
    cap_en     = 1'b0;
    conv_start = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nxt = START;
      end
      START: begin
        conv_start = 1'b1;
        state_nxt  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (conv_done) begin
          addr_nxt  = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = CAPTURE;
      CAPTURE: begin
        cap_en    = 1'b1;
        filt_nxt  = '0;
        state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = last_filt && last_addr;
        if (out_ready) begin
          if (!last_filt) begin
            filt_nxt = filt + IDX_W'(1);
          end else if (!last_addr) begin
            addr_nxt  = addr + ADDR_W'(1);
            state_nxt = FETCH;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p2: filter select from the capture buffer onto the stream ----
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < CONV_NUM; k++) begin
      if (filt == IDX_W'(k)) sel_data = ofm_p1[k];
    end
  end

  // Stream fields are zero outside EMIT so an idle block presents a clean bus.
  assign out_data   = out_valid ? sel_data : '0;
  assign out_filter = out_valid ? filt     : '0;
  assign out_addr   = out_valid ? addr     : '0;

endmodule
